// File: rtl/if_axis_fifo.sv
// Stream-to-CPU FIFO: buffers {flag, payload} beats and exposes DATA/STATUS/CTRL registers.
// Optional level interrupt is built in when IF_AXIS_FIFO_IRQ_EN is defined.
module if_axis_fifo #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter logic [31:0] BASE_ADDR  = 32'hE4000000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       data_i,
   input  logic              data_w_i,
   output logic [31:0]       data_o,
   output logic              data_access_o,
   input  logic              s_axis_tvalid_i,
   output logic              s_axis_tready_o,
   input  logic [DATA_W-1:0] s_axis_tdata_i,
   input  logic              s_axis_tflag_i,
   output logic              irq_o
);
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [3:0] REG_DATA   = 4'd0;
   localparam logic [3:0] REG_STATUS = 4'd1;
   localparam logic [3:0] REG_CTRL   = 4'd2;

   logic [DATA_W:0]       r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_tready;
   logic                  r_rd_prev;
   logic [31:0]           r_data;
   logic [7:0]            r_thresh;

   logic [DEPTH_LOG2:0]   w_count_next;
   logic [DATA_W:0]       w_head;
   logic [31:0]           w_rd_word;
   logic [3:0]            w_reg_sel;
   logic                  w_in_window;
   logic                  w_rd_cycle;
   logic                  w_data_rd;
   logic                  w_pop_edge;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_level;
   logic                  w_ctrl_wr;
   logic                  w_flush;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_rd_load;
   logic                  w_irq_en;
   logic                  w_unused_bits;

   assign w_in_window   = (addr_i[31:8] == BASE_ADDR[31:8]);
   assign w_reg_sel     = addr_i[7:4];
   assign w_rd_cycle    = w_in_window && !data_w_i;
   assign w_data_rd     = w_rd_cycle && (w_reg_sel == REG_DATA);
   // A DATA access held over several cycles pops only on its first cycle.
   assign w_pop_edge    = w_data_rd && !r_rd_prev;
   assign w_empty       = (r_count == '0);
   assign w_full        = (r_count == FULL_CNT);
   assign w_level       = (r_thresh != 8'd0) && (9'(r_count) >= {1'b0, r_thresh});
   assign w_ctrl_wr     = w_in_window && data_w_i && (w_reg_sel == REG_CTRL);
   assign w_flush       = w_ctrl_wr && data_i[0];
   assign w_push        = s_axis_tvalid_i && r_tready && !w_flush;
   assign w_pop         = w_pop_edge && !w_empty && !w_flush;
   assign w_rd_load     = w_rd_cycle && ((w_reg_sel != REG_DATA) || w_pop_edge);
   assign w_head        = r_mem[r_rd_ptr];
   assign w_unused_bits = ^{addr_i[3:0], data_i[31:16], data_i[7:1]};

   assign data_o          = r_data;
   assign data_access_o   = w_in_window;
   assign s_axis_tready_o = r_tready;

   always_comb begin
      w_count_next = r_count;
      if (w_flush) begin
         w_count_next = '0;
      end else if (w_push && !w_pop) begin
         w_count_next = r_count + (DEPTH_LOG2+1)'(1);
      end else if (!w_push && w_pop) begin
         w_count_next = r_count - (DEPTH_LOG2+1)'(1);
      end
   end

   always_comb begin
      w_rd_word = '0;
      case (w_reg_sel)
         REG_DATA: begin
            if (!w_empty) begin
               w_rd_word[31]         = 1'b1;
               w_rd_word[30]         = w_head[DATA_W];
               w_rd_word[DATA_W-1:0] = w_head[DATA_W-1:0];
            end
         end
         REG_STATUS: begin
            w_rd_word[8:0] = 9'(r_count);
            w_rd_word[16]  = w_empty;
            w_rd_word[17]  = w_full;
            w_rd_word[18]  = w_level;
         end
         REG_CTRL: begin
            w_rd_word[1]    = w_irq_en;
            w_rd_word[15:8] = r_thresh;
         end
         default: w_rd_word = '0;
      endcase
   end

   // Storage carries no reset: stale entries are unreachable once pointers clear.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {s_axis_tflag_i, s_axis_tdata_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_tready  <= 1'b0;
         r_rd_prev <= 1'b0;
         r_data    <= '0;
         r_thresh  <= '0;
      end else begin
         r_count   <= w_count_next;
         r_tready  <= (w_count_next != FULL_CNT);
         r_rd_prev <= w_data_rd;
         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
         end
         if (w_rd_load) r_data <= w_rd_word;
         if (w_ctrl_wr) r_thresh <= data_i[15:8];
      end
   end

`ifdef IF_AXIS_FIFO_IRQ_EN
   logic r_irq_en;
   logic r_irq;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_irq_en <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_irq <= r_irq_en && w_level;
         if (w_ctrl_wr) r_irq_en <= data_i[1];
      end
   end

   assign w_irq_en = r_irq_en;
   assign irq_o    = r_irq;
`else
   assign w_irq_en = 1'b0;
   assign irq_o    = 1'b0;
`endif

endmodule
